// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_DRAIN,
        ST_FAULT
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [1:0]  INSTR_ALIGN_MASK     = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & INSTR_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Saturating counter of unacknowledged request cycles; expired once it reaches MAX_WAIT.
module fetch_timeout_ctr #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(MAX_WAIT);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 8'd0;
        end else if (clr) begin
            count <= 8'd0;
        end else if (en && count != LIMIT) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/fetch_ctrl.sv
// Front-end fetch sequencer: PC, imem handshake, output/skid registers, redirect flush, sticky fault.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(DEFAULT_RESET_VECTOR),
    parameter int                    MAX_WAIT     = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_target,
    input  logic                  stall,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  if_valid,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic [DATA_WIDTH-1:0] if_pc,
    output logic [DATA_WIDTH-1:0] if_pcplus4,
    output logic                  fault,
    output fetch_state_e          state_dbg
);

    // Handshakes: a fetch is outstanding from the cycle imem_req rises until the
    // single-cycle imem_ack (which may land in that same cycle); imem_addr stays put
    // meanwhile. Decode takes if_* in any cycle with if_valid=1 and stall=0.

    localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);

    fetch_state_e          state, state_nxt;
    logic [DATA_WIDTH-1:0] pc, drain_addr;
    logic [DATA_WIDTH-1:0] skid_instr, skid_pc;
    logic                  consumed, out_free;
    logic                  capture, to_skid, unskid, flush;
    logic                  pc_inc, pc_load, drain_load;
    logic                  ctr_clr, ctr_en, ctr_expired;

    assign consumed  = if_valid & ~stall;
    assign out_free  = ~if_valid | consumed;
    assign imem_addr = (state == ST_DRAIN) ? drain_addr : pc;
    assign fault     = (state == ST_FAULT);
    assign state_dbg = state;

    fetch_timeout_ctr #(.MAX_WAIT(MAX_WAIT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (ctr_clr),
        .en      (ctr_en),
        .expired (ctr_expired)
    );

    always_comb begin
        state_nxt  = state;
        imem_req   = 1'b0;
        capture    = 1'b0;
        to_skid    = 1'b0;
        unskid     = 1'b0;
        flush      = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        drain_load = 1'b0;
        ctr_en     = 1'b0;
        ctr_clr    = 1'b1;

        case (state)
            ST_BOOT: state_nxt = ST_REQ;
            ST_REQ: begin
                imem_req = out_free;
                if (imem_req && imem_ack) begin
                    capture = 1'b1;
                    pc_inc  = 1'b1;
                end else if (imem_req) begin
                    ctr_en    = 1'b1;
                    ctr_clr   = 1'b0;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    pc_inc = 1'b1;
                    // A stalled decode parks the returning word in the skid.
                    if (stall) begin
                        to_skid   = 1'b1;
                        state_nxt = ST_HOLD;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = ST_REQ;
                    end
                end else begin
                    ctr_en  = 1'b1;
                    ctr_clr = 1'b0;
                    if (ctr_expired) state_nxt = ST_FAULT;
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    unskid    = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_DRAIN: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_nxt = ST_REQ;
                end else begin
                    ctr_en  = 1'b1;
                    ctr_clr = 1'b0;
                    if (ctr_expired) state_nxt = ST_FAULT;
                end
            end
            default: state_nxt = ST_FAULT;
        endcase

        if (redirect_valid && state != ST_FAULT) begin
            capture = 1'b0;
            to_skid = 1'b0;
            unskid  = 1'b0;
            pc_inc  = 1'b0;
            flush   = 1'b1;
            pc_load = 1'b1;
            if (is_misaligned(redirect_target[1:0])) begin
                state_nxt = ST_FAULT;
            end else if (imem_req && !imem_ack) begin
                // The stale fetch must still complete; keep its address for the drain.
                drain_load = (state != ST_DRAIN);
                ctr_en     = 1'b1;
                ctr_clr    = 1'b0;
                state_nxt  = ST_DRAIN;
            end else begin
                state_nxt = ST_REQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_BOOT;
            pc         <= RESET_VECTOR;
            drain_addr <= RESET_VECTOR;
            skid_instr <= '0;
            skid_pc    <= '0;
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_pc      <= '0;
            if_pcplus4 <= '0;
        end else begin
            state <= state_nxt;

            if (pc_load)     pc <= redirect_target;
            else if (pc_inc) pc <= pc + FOUR;

            if (drain_load) drain_addr <= pc;

            if (to_skid) begin
                skid_instr <= imem_rdata;
                skid_pc    <= pc;
            end else if (flush) begin
                skid_instr <= '0;
                skid_pc    <= '0;
            end

            if (flush || state_nxt == ST_FAULT) begin
                if_valid <= 1'b0;
            end else if (capture) begin
                if_valid   <= 1'b1;
                if_instr   <= imem_rdata;
                if_pc      <= pc;
                if_pcplus4 <= pc + FOUR;
            end else if (unskid) begin
                if_valid   <= 1'b1;
                if_instr   <= skid_instr;
                if_pc      <= skid_pc;
                if_pcplus4 <= skid_pc + FOUR;
            end else if (consumed) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule
